// File: rtl/combi_pkg.sv
// combi_pkg: gate opcodes and the shared two-input gate function.
// a is the even tree input, b the odd one.
package combi_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  function automatic logic combi_op(
    input logic [2:0] op,
    input logic       a,
    input logic       b
  );
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_PASS: r = a;
      OP_NOT:  r = ~a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/combi_stage.sv
// combi_stage: one tree level; W inputs -> W/2 registered gate outputs.
// Ports: up_valid/up_data in, ops per gate, dn_adv in, adv/valid/data out.
module combi_stage
  import combi_pkg::*;
#(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [W-1:0]     up_data,
  input  logic [3*(W/2)-1:0] ops,
  input  logic             dn_adv,
  output logic             adv,
  output logic             valid,
  output logic [W/2-1:0]   data
);

  localparam int G = W / 2;

  logic         v_q, v_d;
  logic [G-1:0] data_q, data_d;
  logic [G-1:0] gate;

  always_comb begin
    gate = '0;
    for (int g = 0; g < G; g++) begin
      gate[g] = combi_op(ops[3*g +: 3],
                         up_data[2*g],
                         up_data[2*g+1]);
    end
    // an empty stage always takes from upstream
    adv    = !v_q || dn_adv;
    v_d    = v_q;
    data_d = data_q;
    if (adv) begin
      v_d = up_valid;
      if (up_valid) data_d = gate;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) v_q <= 1'b0;
    else        v_q <= v_d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid = v_q;
  assign data  = data_q;

endmodule

// File: rtl/combi_pipe.sv
// combi_pipe: pipelined configurable gate tree, 2**LEVELS bits -> 1 bit.
// Ports: in_* / out_* valid-ready streams, cfg_load/cfg_ops/cfg_err, busy, out_cnt.
module combi_pipe
  import combi_pkg::*;
#(
  parameter int         LEVELS     = 4,
  parameter logic [2:0] DEFAULT_OP = 3'd0,
  parameter int         CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2**LEVELS-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_data,
  input  logic                    cfg_load,
  input  logic [3*(2**LEVELS-1)-1:0] cfg_ops,
  output logic                    cfg_err,
  output logic                    busy,
  output logic [CNT_W-1:0]        out_cnt
);

  localparam int N_IN = 2 ** LEVELS;
  localparam int N_G  = N_IN - 1;
  localparam int OW   = 3 * N_G;

  logic [OW-1:0]    ops_q, ops_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [LEVELS-1:0] v;
  logic [LEVELS:0]   adv;
  // bit k holds the registered output of gate k
  logic [N_G-1:0]    tree;

  logic in_xfer, out_xfer, cfg_ok;

  assign adv[LEVELS] = out_ready;

  for (genvar s = 0; s < LEVELS; s++) begin : g_stage
    localparam int W    = N_IN >> s;
    localparam int BASE = N_IN - W;

    logic [W-1:0] up_data;
    logic         up_valid;

    if (s == 0) begin : g_first
      assign up_data  = in_data;
      assign up_valid = in_valid;
    end else begin : g_rest
      assign up_data  = tree[N_IN-2*W +: W];
      assign up_valid = v[s-1];
    end

    combi_stage #(
      .W(W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_valid),
      .up_data  (up_data),
      .ops      (ops_q[3*BASE +: 3*(W/2)]),
      .dn_adv   (adv[s+1]),
      .adv      (adv[s]),
      .valid    (v[s]),
      .data     (tree[BASE +: W/2])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = v[LEVELS-1];
  assign out_data  = tree[N_G-1];
  assign busy      = |v;
  assign out_cnt   = cnt_q;
  assign cfg_err   = err_q;

  always_comb begin
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
    // ops only change with the tree empty and no word entering
    cfg_ok   = cfg_load && !busy && !in_xfer;
    ops_d    = cfg_ok ? cfg_ops : ops_q;
    cnt_d    = cnt_q + CNT_W'(out_xfer);
    err_d    = cfg_load && !cfg_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ops_q <= {N_G{DEFAULT_OP}};
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ops_q <= ops_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule
